// File: rtl/flg_sched_pkg.sv
// Shared defaults and state encoding for the flag-match scheduler.
package flg_sched_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_BASE_WIDTH = 12;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/flg_match_find.sv
// Combinational lowest-set-bit finder with prefix popcounts of the act/wei flags
// below that bit; clrMask is the one-hot of the found position.
module flg_match_find #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0] matchVec,
  input  logic [DATA_WIDTH-1:0] act,
  input  logic [DATA_WIDTH-1:0] wei,
  output logic [ADDR_WIDTH-1:0] pos,
  output logic [ADDR_WIDTH:0]   offAct,
  output logic [ADDR_WIDTH:0]   offWei,
  output logic [DATA_WIDTH-1:0] clrMask
);

  logic [DATA_WIDTH-1:0] below;

  always_comb begin
    clrMask = matchVec & (~matchVec + DATA_WIDTH'(1));
    // An empty match must yield zero offsets, not a full-word count.
    below   = (matchVec == '0) ? '0 : (clrMask - DATA_WIDTH'(1));
    pos     = '0;
    offAct  = '0;
    offWei  = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (clrMask[i]) pos = ADDR_WIDTH'(i);
      offAct = offAct + (ADDR_WIDTH+1)'(act[i] & below[i]);
      offWei = offWei + (ADDR_WIDTH+1)'(wei[i] & below[i]);
    end
  end

endmodule

// File: rtl/flg_sched.sv
// Scans the AND of two flag words LSB first, emitting one beat per matched
// position with compressed-buffer offsets and running base addresses.
module flg_sched
  import flg_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BASE_WIDTH = DEF_BASE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_flg_act,
  input  logic [DATA_WIDTH-1:0] in_flg_wei,
  input  logic                  clr_base,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   out_offset_act,
  output logic [ADDR_WIDTH:0]   out_offset_wei,
  output logic [BASE_WIDTH-1:0] out_addr_act,
  output logic [BASE_WIDTH-1:0] out_addr_wei,
  output logic                  out_last,
  output logic                  out_empty,
  output logic                  busy
);

  state_e                state, stateNext;
  logic [DATA_WIDTH-1:0] actQ, weiQ, remQ, remNext, clrMask;
  logic [ADDR_WIDTH-1:0] pos;
  logic [ADDR_WIDTH:0]   offAct, offWei;
  logic [ADDR_WIDTH:0]   cntActQ, cntWeiQ, cntActIn, cntWeiIn;
  logic [BASE_WIDTH-1:0] baseAct, baseWei;
  logic                  scan, accept, lastDone;

  flg_match_find #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) uFind (
    .matchVec(remQ),
    .act     (actQ),
    .wei     (weiQ),
    .pos     (pos),
    .offAct  (offAct),
    .offWei  (offWei),
    .clrMask (clrMask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    scan      = (state == SCAN);
    out_valid = scan;
    busy      = scan;
    out_empty = scan && (remQ == '0);
    out_last  = scan && ((remQ & ~clrMask) == '0);
    // Accepting alongside the last beat keeps the beat stream gap-free.
    in_ready  = !scan || (out_ready && out_last);
    accept    = in_valid && in_ready;
    lastDone  = scan && out_ready && out_last;
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = SCAN;
      SCAN:    if (lastDone) stateNext = accept ? SCAN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    remNext      = remQ;
    remNext[pos] = 1'b0;
    cntActIn     = '0;
    cntWeiIn     = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      cntActIn = cntActIn + (ADDR_WIDTH+1)'(in_flg_act[i]);
      cntWeiIn = cntWeiIn + (ADDR_WIDTH+1)'(in_flg_wei[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      actQ    <= '0;
      weiQ    <= '0;
      remQ    <= '0;
      cntActQ <= '0;
      cntWeiQ <= '0;
      baseAct <= '0;
      baseWei <= '0;
    end else begin
      if (accept) begin
        actQ    <= in_flg_act;
        weiQ    <= in_flg_wei;
        remQ    <= in_flg_act & in_flg_wei;
        cntActQ <= cntActIn;
        cntWeiQ <= cntWeiIn;
      end else if (scan && out_ready) begin
        remQ <= remNext;
      end
      // Clear takes priority over the end-of-word advance.
      if (clr_base) begin
        baseAct <= '0;
        baseWei <= '0;
      end else if (lastDone) begin
        baseAct <= baseAct + BASE_WIDTH'(cntActQ);
        baseWei <= baseWei + BASE_WIDTH'(cntWeiQ);
      end
    end
  end

  always_comb begin
    out_offset_act = scan ? offAct : '0;
    out_offset_wei = scan ? offWei : '0;
    out_addr_act   = scan ? (baseAct + BASE_WIDTH'(offAct)) : '0;
    out_addr_wei   = scan ? (baseWei + BASE_WIDTH'(offWei)) : '0;
  end

endmodule

// File: tb/tb_flg_sched.sv
// Bench for flg_sched: directed scenarios plus randomized words checked against
// a queue of expected beats derived from the flag words.
module tb_flg_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_flg_act, in_flg_wei;
  logic        clr_base;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_offset_act, out_offset_wei;
  logic [11:0] out_addr_act, out_addr_wei;
  logic        out_last, out_empty, busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int offA;
    int offW;
    bit last;
    bit empty;
    int cntA;
    int cntW;
  } beat_t;

  beat_t q[$];
  int    mBaseA = 0;
  int    mBaseW = 0;

  flg_sched dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_flg_act    (in_flg_act),
    .in_flg_wei    (in_flg_wei),
    .clr_base      (clr_base),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_offset_act(out_offset_act),
    .out_offset_wei(out_offset_wei),
    .out_addr_act  (out_addr_act),
    .out_addr_wei  (out_addr_wei),
    .out_last      (out_last),
    .out_empty     (out_empty),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_word(input logic [31:0] a, input logic [31:0] w);
    logic [31:0] m;
    logic [31:0] low;
    int n, k, ca, cw;
    beat_t b;
    m  = a & w;
    n  = $countones(m);
    ca = $countones(a);
    cw = $countones(w);
    k  = 0;
    if (n == 0) begin
      b = '{0, 0, 1'b1, 1'b1, ca, cw};
      q.push_back(b);
    end else begin
      for (int p = 0; p < 32; p++) begin
        if (m[p]) begin
          k++;
          low = (32'h1 << p) - 32'h1;
          b = '{$countones(a & low), $countones(w & low), (k == n), 1'b0, ca, cw};
          q.push_back(b);
        end
      end
    end
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] w);
    in_valid   = 1'b1;
    in_flg_act = a;
    in_flg_wei = w;
    #1;
    chk("idle_out_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 1);
    push_word(a, w);
    step();
    in_valid   = 1'b0;
    in_flg_act = $urandom;
    in_flg_wei = $urandom;
  endtask

  task automatic clear_bases();
    clr_base = 1'b1;
    step();
    clr_base = 1'b0;
    mBaseA = 0;
    mBaseW = 0;
  endtask

  // mode 0: always ready, 1: random ready, 2: three-cycle stall at beat 1
  task automatic drain(input int mode, input int clrAt, input int stopAfter,
                       input bit haveNext, input logic [31:0] nAct, input logic [31:0] nWei);
    int    beat  = 0;
    int    stall = 0;
    int    guard = 0;
    bit    pend  = haveNext;
    bit    rdy, nextNow, clr;
    beat_t b;
    while (q.size() > 0 && beat != stopAfter && guard < 2000) begin
      guard++;
      case (mode)
        1:       rdy = 1'($urandom_range(0, 1));
        2:       rdy = !(beat == 1 && stall < 3);
        default: rdy = 1'b1;
      endcase
      if (!rdy) stall++;
      if (pend && q[0].last) rdy = 1'b1;
      nextNow    = pend && q[0].last;
      clr        = rdy && (beat == clrAt);
      out_ready  = rdy;
      clr_base   = clr;
      in_valid   = nextNow;
      in_flg_act = nextNow ? nAct : $urandom;
      in_flg_wei = nextNow ? nWei : $urandom;
      #1;
      b = q[0];
      chk("out_valid", out_valid, 1);
      chk("busy", busy, 1);
      chk("off_act", out_offset_act, b.offA);
      chk("off_wei", out_offset_wei, b.offW);
      chk("addr_act", out_addr_act, (mBaseA + b.offA) % 4096);
      chk("addr_wei", out_addr_wei, (mBaseW + b.offW) % 4096);
      chk("last", out_last, b.last);
      chk("empty", out_empty, b.empty);
      chk("in_ready", in_ready, rdy && b.last);
      if (rdy) begin
        void'(q.pop_front());
        beat++;
        if (clr) begin
          mBaseA = 0;
          mBaseW = 0;
        end else if (b.last) begin
          mBaseA = (mBaseA + b.cntA) % 4096;
          mBaseW = (mBaseW + b.cntW) % 4096;
        end
      end
      if (nextNow) begin
        push_word(nAct, nWei);
        pend = 1'b0;
      end
      step();
      in_valid = 1'b0;
      clr_base = 1'b0;
    end
    if (stopAfter < 0) chk("drain_done", q.size(), 0);
  endtask

  initial begin
    logic [31:0] a, w, a2, w2;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    clr_base   = 1'b0;
    in_flg_act = '0;
    in_flg_wei = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_empty", out_empty, 0);
    chk("rst_busy", busy, 0);
    chk("rst_off_act", out_offset_act, 0);
    chk("rst_addr_wei", out_addr_wei, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    step();

    // Two-match word from zero bases, then an empty word that exposes bases 4/2
    send(32'h0000000F, 32'h0000000A);
    drain(0, -1, -1, 1'b0, '0, '0);
    chk("model_base_act_4", mBaseA, 4);
    chk("model_base_wei_2", mBaseW, 2);
    send(32'hFFFF0000, 32'h0000FFFF);
    drain(0, -1, -1, 1'b0, '0, '0);

    // Preset bases to 4080 via empty words, then a full word wraps addresses
    clear_bases();
    for (int i = 0; i < 255; i++) begin
      send(32'hFFFF0000, 32'h0000FFFF);
      drain(0, -1, -1, 1'b0, '0, '0);
    end
    send(32'hFFFFFFFF, 32'hFFFFFFFF);
    drain(0, -1, -1, 1'b0, '0, '0);
    chk("wrap_base_act", mBaseA, 16);
    send(32'h00000000, 32'h00000000);
    drain(0, -1, -1, 1'b0, '0, '0);

    // Stall mid-word
    send(32'h0000F0F0, 32'h000030F0);
    drain(2, -1, -1, 1'b0, '0, '0);

    // Back-to-back words
    send(32'h00000F00, 32'h00000500);
    drain(0, -1, -1, 1'b1, 32'h000000FF, 32'h00000081);

    // Clear on a last beat, then clear mid-word
    send(32'h0000000F, 32'h0000000A);
    drain(0, 1, -1, 1'b0, '0, '0);
    send(32'h00000303, 32'h00000103);
    drain(0, 0, -1, 1'b0, '0, '0);

    // Reset on the second beat of a four-match word
    send(32'h00001111, 32'h00001111);
    drain(0, -1, 1, 1'b0, '0, '0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_last", out_last, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    mBaseA = 0;
    mBaseW = 0;
    #1;
    chk("postrst_in_ready", in_ready, 1);
    step();
    chk("postrst_out_valid", out_valid, 0);
    send(32'h00000006, 32'h00000006);
    drain(0, -1, -1, 1'b0, '0, '0);

    // Randomized words with random backpressure and back-to-back pairs
    for (int i = 0; i < 60; i++) begin
      a  = $urandom;
      w  = ($urandom_range(0, 4) == 0) ? ~a : ($urandom & $urandom);
      a2 = $urandom & $urandom;
      w2 = $urandom;
      send(a, w);
      if (i % 2 == 0) begin
        drain(1, -1, -1, 1'b1, a2, w2);
      end else begin
        drain(1, (i % 7 == 0) ? 0 : -1, -1, 1'b0, '0, '0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flg_sched.md
FLG_SCHED -- requirements
Module: flg_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 32: flag word width, one bit per block position.
REQ-002 Parameter ADDR_WIDTH, default 5: log2(DATA_WIDTH); offsets are ADDR_WIDTH+1 bits wide.
REQ-003 Parameter BASE_WIDTH, default 12: width of the compressed-buffer base/address counters.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  flag-word pair offered.
REQ-008 in_ready  output  1  flag-word pair accepted when in_valid&in_ready.
REQ-009 in_flg_act  input  DATA_WIDTH  activation nonzero flags.
REQ-010 in_flg_wei  input  DATA_WIDTH  weight nonzero flags.
REQ-011 clr_base  input  1  synchronous clear of both base counters.
REQ-012 out_valid  output  1  match beat present.
REQ-013 out_ready  input  1  downstream accepts beat.
REQ-014 out_offset_act / out_offset_wei  output  ADDR_WIDTH+1  in-word compressed index of the matched element.
REQ-015 out_addr_act / out_addr_wei  output  BASE_WIDTH  base + offset, modulo 2^BASE_WIDTH.
REQ-016 out_last  output  1  final beat of the current word.
REQ-017 out_empty  output  1  word had no match; beat carries no valid offsets.
REQ-018 busy  output  1  state != IDLE.

Function
REQ-019 States are IDLE and SCAN; in IDLE, in_ready=1 and out_valid=0.
REQ-020 Acceptance latches act, wei and match=act&wei, then goes to SCAN; the first beat is valid on the next cycle.
REQ-021 In SCAN, out_valid=1 and the beat is position p = lowest set bit of the remaining match (LSB first).
REQ-022 Offsets: out_offset_act=popcount(act[p-1:0]); out_offset_wei=popcount(wei[p-1:0]); both are 0 for p=0.
REQ-023 Zero-match word: exactly one beat with out_empty=1, out_last=1 and offsets 0.
REQ-024 out_last=1 when the remaining match has exactly one set bit, or on an empty beat.
REQ-025 On out_valid&out_ready, bit p is cleared from the remaining match; all outputs hold stable while out_ready=0.
REQ-026 On handshake of the last beat, base_act += popcount(act) and base_wei += popcount(wei), wrapping modulo 2^BASE_WIDTH.
REQ-027 After the last-beat handshake, state returns to IDLE, or stays in SCAN if a new word is accepted in the same cycle.
REQ-028 in_ready is also 1 in SCAN when out_ready&out_last, giving back-to-back words with no bubble: one beat per cycle sustained.
REQ-029 clr_base zeroes both bases at the next edge in any state.
REQ-030 clr_base coincident with a base update: the clear wins, so bases are 0.
REQ-031 clr_base mid-word: the remaining beats use base 0.
REQ-032 The in_flg_* inputs are ignored unless in_valid&in_ready.

Reset
REQ-033 rst forces IDLE; clears bases and latched flags to 0; out_valid=0, out_last=0, out_empty=0, busy=0, all offsets/addresses 0, and in_ready=1 once rst deasserts.
REQ-034 rst mid-SCAN discards the word in flight; no further beats from it are emitted.

Structure
REQ-035 DATA_WIDTH/ADDR_WIDTH defaults and the state encoding (IDLE=0, SCAN=1) live in the shared params include.
REQ-036 Sub-module flg_match_find: combinational lowest-set-bit finder plus masked prefix popcounts of act/wei; it returns p, both offsets and a one-hot clear mask.
REQ-037 The whole-word popcounts for the base update are computed once at acceptance and registered.

Verification
REQ-038 Directed: act=0x0000000F, wei=0x0000000A, bases 0, out_ready=1 -> beat1 p=1 off_act=1 off_wei=0; beat2 p=3 off_act=3 off_wei=1 last=1; then bases 4/2.
REQ-039 Directed: act=0xFFFF0000, wei=0x0000FFFF -> single beat empty=1 last=1; bases +16/+16.
REQ-040 Directed: act=wei=0xFFFFFFFF with bases preset to 4080 -> 32 beats with offsets 0..31 and addresses wrapping through 4095 to 0..15; last on beat 32; bases become 16/16.
REQ-041 Directed: out_ready low for 3 cycles mid-word -> outputs frozen, no beat lost or duplicated.
REQ-042 Directed: two words queued with out_ready=1 -> the second word's first beat follows the first word's last beat on the next cycle.
REQ-043 Directed: rst pulse on the 2nd beat of a 4-match word -> IDLE next cycle, bases 0, no further beats; clr_base on a last beat -> bases 0.
